// File: rtl/code_entry_unit_pkg.sv
// Shared safe-controller constants: display modes and special keypad codes.
// Imported by the keypad-side datapath and the display driver.
package code_entry_unit_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_ENTRY = 2'd1;
    localparam logic [1:0] MODE_OPEN  = 2'd2;
    localparam logic [1:0] MODE_ALARM = 2'd3;

    localparam logic [3:0] KEY_BACK  = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/code_entry_unit_key_strobe_sync.sv
// Brings the asynchronous key_valid level into the clk domain and turns each
// press into a single-cycle strobe.
module key_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic key_valid,
    output logic strobe
);

    // [0],[1] are the synchronizer; [2] remembers the previous synced level.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], key_valid};
        end
    end

    assign strobe = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/code_entry_unit.sv
// Keypad-side passcode entry: collects digits, reports submit/match to the
// safe controller, stores the passcode on request.
module code_entry_unit
    import code_entry_unit_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    accept_digit,
    input  logic                    clear_entry,
    input  logic                    load_code,
    output logic                    done,
    output logic                    match,
    output logic                    key_reject,
    output logic [4*NUM_DIGITS-1:0] entry_digits,
    output logic [CNT_W-1:0]        entry_count,
    output logic                    code_valid
);

    localparam int                W    = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DONE    = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             strobe;
    logic [W-1:0]     stored;
    logic [W-1:0]     entry_next;
    logic [CNT_W-1:0] count_next;
    logic             match_next, done_next, reject_next;

    key_strobe_sync u_key_strobe_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .strobe    (strobe)
    );

    always_comb begin
        state_next  = state;
        entry_next  = entry_digits;
        count_next  = entry_count;
        match_next  = match;
        done_next   = 1'b0;
        reject_next = 1'b0;

        case (state)
            S_COLLECT: begin
                if (strobe && accept_digit) begin
                    if (is_digit(key_code)) begin
                        if (entry_count < FULL) begin
                            entry_next = (entry_digits << 4) | W'(key_code);
                            count_next = entry_count + ONE;
                        end else begin
                            reject_next = 1'b1;
                        end
                    end else if (key_code == KEY_BACK) begin
                        if (entry_count != '0) begin
                            entry_next = entry_digits >> 4;
                            count_next = entry_count - ONE;
                        end else begin
                            reject_next = 1'b1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        if (entry_count == FULL) begin
                            state_next = S_DONE;
                            done_next  = 1'b1;
                            match_next = code_valid && (entry_digits == stored);
                        end else begin
                            reject_next = 1'b1;
                        end
                    end
                end
            end
            S_DONE:  state_next = S_HOLD;
            S_HOLD:  state_next = S_HOLD;
            default: state_next = S_COLLECT;
        endcase

        // Clear overrides everything, including a strobe landing in the same cycle.
        if (clear_entry) begin
            state_next  = S_COLLECT;
            entry_next  = '0;
            count_next  = '0;
            match_next  = 1'b0;
            done_next   = 1'b0;
            reject_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_COLLECT;
            entry_digits <= '0;
            entry_count  <= '0;
            match        <= 1'b0;
            done         <= 1'b0;
            key_reject   <= 1'b0;
        end else begin
            state        <= state_next;
            entry_digits <= entry_next;
            entry_count  <= count_next;
            match        <= match_next;
            done         <= done_next;
            key_reject   <= reject_next;
        end
    end

    // Stores the pre-clear entry even when clear_entry arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored     <= '0;
            code_valid <= 1'b0;
        end else if (load_code) begin
            stored     <= entry_digits;
            code_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_code_entry_unit.sv
// Bench for code_entry_unit: directed scenarios then random key/controller
// traffic, checked against a digit-list model of the entry.
module tb_code_entry_unit;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        accept_digit;
    logic        clear_entry;
    logic        load_code;
    logic        done;
    logic        match;
    logic        key_reject;
    logic [15:0] entry_digits;
    logic [2:0]  entry_count;
    logic        code_valid;

    code_entry_unit #(.NUM_DIGITS(N), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .accept_digit (accept_digit),
        .clear_entry  (clear_entry),
        .load_code    (load_code),
        .done         (done),
        .match        (match),
        .key_reject   (key_reject),
        .entry_digits (entry_digits),
        .entry_count  (entry_count),
        .code_valid   (code_valid)
    );

    always #5 clk = ~clk;

    // Reference model: entered digits oldest-first, plus controller-visible flags.
    int          digits[$];
    logic [15:0] m_stored;
    bit          m_cv;
    bit          m_hold;
    bit          m_match;

    int   done_cnt;
    int   rej_cnt;
    logic last_match;
    int   n_checks;
    int   n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_value();
        logic [15:0] v = '0;
        foreach (digits[i]) v = (v << 4) | 16'(digits[i]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                last_match = match;
            end
            if (key_reject) rej_cnt++;
            if (done || key_reject) check("done_reject_exclusive", 32'(done & key_reject), 32'd0);
        end
    end

    task automatic check_state(input string tag);
        check({tag, "_entry"}, 32'(entry_digits), 32'(m_value()));
        check({tag, "_count"}, 32'(entry_count), 32'(digits.size()));
        check({tag, "_code_valid"}, 32'(code_valid), 32'(m_cv));
        check({tag, "_match"}, 32'(match), 32'(m_match));
    endtask

    task automatic model_reset();
        digits.delete();
        m_stored = '0;
        m_cv     = 0;
        m_hold   = 0;
        m_match  = 0;
    endtask

    task automatic press(input logic [3:0] k, input bit acc, input int hold);
        int d0 = done_cnt;
        int r0 = rej_cnt;
        int exp_done = 0;
        int exp_rej = 0;
        if (acc && !m_hold) begin
            if (k <= 4'd9) begin
                if (digits.size() < N) digits.push_back(int'(k));
                else exp_rej = 1;
            end else if (k == 4'hA) begin
                if (digits.size() > 0) void'(digits.pop_back());
                else exp_rej = 1;
            end else if (k == 4'hB) begin
                if (digits.size() == N) begin
                    exp_done = 1;
                    m_match  = m_cv && (m_value() == m_stored);
                    m_hold   = 1;
                end else begin
                    exp_rej = 1;
                end
            end
        end
        @(negedge clk);
        accept_digit = acc;
        key_code     = k;
        key_valid    = 1'b1;
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), 32'(exp_done));
        check("reject_pulses", 32'(rej_cnt - r0), 32'(exp_rej));
        if (exp_done != 0) check("match_at_done", 32'(last_match), 32'(m_match));
        check_state("press");
    endtask

    task automatic ctrl(input bit ld, input bit clr);
        @(negedge clk);
        load_code   = ld;
        clear_entry = clr;
        @(negedge clk);
        load_code   = 1'b0;
        clear_entry = 1'b0;
        if (ld) begin
            m_stored = m_value();
            m_cv     = 1;
        end
        if (clr) begin
            digits.delete();
            m_hold  = 0;
            m_match = 0;
        end
        repeat (2) @(negedge clk);
        check_state("ctrl");
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) press(code[4*i +: 4], 1'b1, 2);
        press(4'hB, 1'b1, 2);
    endtask

    initial begin
        int r0;
        done_cnt = 0;
        rej_cnt  = 0;
        n_checks = 0;
        n_fail   = 0;
        rst_n        = 1'b0;
        key_valid    = 1'b0;
        key_code     = 4'h0;
        accept_digit = 1'b1;
        clear_entry  = 1'b0;
        load_code    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_done", 32'(done), 32'd0);
        check("reset_reject", 32'(key_reject), 32'd0);
        check_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // First submission with no stored code, then store it.
        enter_code(16'h1234);
        ctrl(1'b1, 1'b0);
        ctrl(1'b0, 1'b1);
        enter_code(16'h1234);
        ctrl(1'b0, 1'b1);
        enter_code(16'h1235);
        ctrl(1'b0, 1'b1);

        // Backspace and underflow/short-entry rejects.
        press(4'h7, 1'b1, 2);
        press(4'h8, 1'b1, 2);
        press(4'hA, 1'b1, 2);
        press(4'hA, 1'b1, 2);
        press(4'hA, 1'b1, 2);
        press(4'hB, 1'b1, 2);
        press(4'hC, 1'b1, 2);

        // Overflow, then a long hold producing one digit.
        for (int i = 1; i <= 5; i++) press(4'(i), 1'b1, 2);
        ctrl(1'b0, 1'b1);
        press(4'h6, 1'b1, 50);
        press(4'h6, 1'b1, 3);
        press(4'h6, 1'b1, 1);
        press(4'h6, 1'b1, 4);
        press(4'hB, 1'b1, 2);
        press(4'h9, 1'b1, 2);
        press(4'hA, 1'b1, 2);
        ctrl(1'b0, 1'b1);
        press(4'h3, 1'b0, 2);

        // Strobe lands in the same cycle as clear_entry.
        press(4'h1, 1'b1, 2);
        r0 = rej_cnt;
        @(negedge clk);
        key_code  = 4'h5;
        key_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear_entry = 1'b1;
        @(negedge clk);
        clear_entry = 1'b0;
        key_valid   = 1'b0;
        repeat (4) @(negedge clk);
        digits.delete();
        check("clear_strobe_reject", 32'(rej_cnt - r0), 32'd0);
        check_state("clear_strobe");

        // Asynchronous reset while holding after a submit.
        ctrl(1'b1, 1'b0);
        enter_code(16'h4321);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_reject", 32'(key_reject), 32'd0);
        check_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // load_code together with clear_entry stores the pre-clear entry.
        press(4'h4, 1'b1, 2);
        press(4'h2, 1'b1, 2);
        ctrl(1'b1, 1'b1);
        enter_code(16'h0042);
        ctrl(1'b0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            int sel = $urandom_range(0, 19);
            if (sel == 0) begin
                ctrl(1'($urandom_range(0, 1)), 1'b1);
            end else if (sel == 1) begin
                ctrl(1'b1, 1'b0);
            end else if (sel < 5) begin
                press(4'($urandom_range(10, 15)), $urandom_range(0, 5) != 0, $urandom_range(1, 4));
            end else begin
                press(4'($urandom_range(0, 3)), $urandom_range(0, 5) != 0, $urandom_range(1, 4));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/code_entry_unit.md
Name: code_entry_unit

Overview:
Keypad-side datapath and handshake responder for safe_controller_fsm. It accepts key presses only while the controller asserts accept_digit, collects a NUM_DIGITS passcode, and raises a one-cycle done with a valid match flag. It stores the code on load_code and wipes the entry on clear_entry. It sits between the keypad scanner and the controller, and also feeds the entry digits to the display driver.

Parameters:
NUM_DIGITS, 4, passcode length in decimal digits (1..8)
CNT_W, 3, width of entry_count; must hold the value NUM_DIGITS

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  keypad press level, asynchronous to clk; high while a key is held
key_code  input  4  key value: 0-9 digit, KEY_BACK=4'hA, KEY_ENTER=4'hB, C-F unused; stable while key_valid is high
accept_digit  input  1  controller permits key processing
clear_entry  input  1  controller request to wipe the entry
load_code  input  1  controller request to store the entry as the passcode
done  output  1  one-cycle pulse: a complete code was submitted
match  output  1  entry equals the stored code; valid while done is high
key_reject  output  1  one-cycle pulse: the key was illegal in the current context
entry_digits  output  4*NUM_DIGITS  BCD entry; the newest digit is in nibble 0
entry_count  output  CNT_W  number of digits currently entered
code_valid  output  1  a code has been stored since reset

Behaviour:
- Reset (async, rst_n low): entry_digits=0, entry_count=0, stored code=0, code_valid=0, done=0, match=0, key_reject=0, FSM=S_COLLECT, synchronizer flops=0. A reset mid-entry or mid-done discards everything immediately.
- Key strobe:
  - key_valid passes a 2-flop synchronizer, then a rising-edge detect.
  - Edge E0 first samples key_valid=1. The strobe is high in the cycle after E1. The action registers at E2.
  - Each press yields exactly one strobe, however long the key is held.
- FSM states: S_COLLECT, S_DONE, S_HOLD.
- S_COLLECT, strobe with accept_digit=1:
  - Digit 0-9, count<N: entry_digits = {entry_digits[4N-5:0], digit}; count+1.
  - Digit 0-9, count==N: no change; key_reject pulse.
  - KEY_BACK, count>0: entry_digits shifts right one nibble, top nibble becomes 0; count-1.
  - KEY_BACK, count==0: key_reject pulse.
  - KEY_ENTER, count==N: go to S_DONE; match <= code_valid && (entry_digits==stored).
  - KEY_ENTER, count<N: key_reject pulse; stay in S_COLLECT.
  - Codes C-F: ignored silently.
- Strobe with accept_digit=0: ignored with no reject, in any state.
- S_DONE: done=1 for exactly one cycle, then unconditionally go to S_HOLD.
- S_HOLD: all keys ignored with no reject. Entry and match are held until clear_entry.
- clear_entry (any state, highest priority):
  - Next edge: entry_digits=0, count=0, match=0, FSM=S_COLLECT.
  - A strobe in the same cycle is discarded.
  - If in S_DONE, done still completes its single cycle; the FSM goes to S_COLLECT instead of S_HOLD.
- load_code:
  - Next edge: stored <= current entry_digits; code_valid <= 1.
  - If clear_entry is asserted in the same cycle, the pre-clear entry is stored.
  - load_code while count<N still stores the entry with zero-padded upper nibbles; this is legal and not flagged.
- done, match and key_reject are registered outputs. No combinational path from inputs to outputs.
- Controller handshake:
  - The controller samples done and match in the same cycle.
  - load_code arrives the cycle after done, while the entry is still held.
  - clear_entry follows in the next cycle.
- key_reject and done are never high in the same cycle.

Decomposition:
- Add KEY_BACK (4'hA) and KEY_ENTER (4'hB) to the shared team params header, alongside the existing MODE_* display constants.
- FSM state localparams stay local to the module.
- One sub-module: key_strobe_sync. It contains the 2-flop synchronizer plus the rising-edge pulse, and has ports clk, rst_n, key_valid, strobe.

Test Plan:
- Reset, accept_digit=1, press 1,2,3,4 then ENTER -> entry_digits=16'h1234 and count=4. done pulses 1 cycle with match=0 (code_valid=0). key_reject is never asserted.
- Continue: load_code 1 cycle, then clear_entry -> code_valid=1, entry=0, count=0. Press 1,2,3,4,ENTER -> done with match=1. Press 1,2,3,5,ENTER -> done with match=0.
- Press 7,8 then BACK -> entry=16'h0007, count=1. BACK twice -> second BACK gives a key_reject pulse with count=0. ENTER at count=0 -> key_reject, no done.
- Press 5 digits -> fifth gives a key_reject and entry keeps the first four. Hold key_valid high for 50 cycles -> only one digit is entered.
- After done, press 9 in S_HOLD -> no change and no reject. Press with accept_digit=0 -> ignored. Assert clear_entry in the same cycle as a strobe -> entry=0 and the strobe is lost.
- Drop rst_n while in S_HOLD with code_valid=1 -> all outputs 0 immediately, code_valid=0. Apply load_code together with clear_entry -> the pre-clear entry is stored.
